imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_SIZE, default 1024: instruction-memory size in bytes; writes at address >= MEM_SIZE are illegal.
REQ-002 Parameter CNT_W, default 16: width of the payload byte counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a load session; sampled only in IDLE.
REQ-006 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
REQ-009 wEn  output  1  instruction-memory write enable, one byte per cycle.
REQ-010 waddr  output  64  instruction-memory byte address.
REQ-011 wdata  output  8  instruction-memory write byte.
REQ-012 cpu_hold  output  1  high while the loader is not in IDLE; holds the pipeline in stall.
REQ-013 done  output  1  one-cycle pulse on successful completion.
REQ-014 err  output  1  sticky error flag; cleared when the next start is accepted.
REQ-015 bytes_written  output  CNT_W  count of payload bytes written in the current or last session.

Function
REQ-016 Stream format, in order: 8-byte base address (little-endian), 2-byte payload length N (little-endian), N payload bytes, 1-byte checksum equal to the XOR of all payload bytes.
REQ-017 States: IDLE, ADDR, LEN, DATA, CSUM, DONE, ERR.
REQ-018 IDLE -> ADDR on start; the same edge clears err, bytes_written, checksum accumulator and byte index.
REQ-019 ADDR: accept 8 bytes; byte k loads base[8k+7:8k]; -> LEN after byte 7.
REQ-020 LEN: accept 2 bytes into N.
REQ-021 LEN -> ERR after the second byte if base + N > MEM_SIZE; the sum is computed 65 bits wide so overflow also errors.
REQ-022 LEN -> CSUM after the second byte if N == 0; otherwise LEN -> DATA.
REQ-023 DATA: each accepted byte i (0..N-1) produces, on the next cycle, wEn=1, waddr=base+i, wdata=byte.
REQ-024 DATA: the same accepted byte increments bytes_written and XORs into the accumulator; -> CSUM after byte N-1.
REQ-025 Write latency is exactly one cycle from handshake to wEn; back-to-back handshakes give back-to-back writes.
REQ-026 wEn is 0 in every cycle not following a DATA handshake.
REQ-027 CSUM: accept 1 byte; -> DONE if it equals the accumulator, else -> ERR.
REQ-028 DONE: done=1 for one cycle, then -> IDLE.
REQ-029 ERR: err set, then -> IDLE; writes already issued are not undone.
REQ-030 in_ready = 1 in ADDR, LEN, DATA and CSUM; 0 in IDLE, DONE and ERR.
REQ-031 When in_valid=0, no state advances; stalls of any length are legal.
REQ-032 start is ignored outside IDLE.
REQ-033 cpu_hold = (state != IDLE); it covers the DONE and ERR cycles.
REQ-034 When the source presents in_valid with no session open, the loader does not consume the byte.

Reset
REQ-035 On rst: state=IDLE, in_ready=0, wEn=0, waddr=0, wdata=0, cpu_hold=0, done=0, err=0, bytes_written=0.
REQ-036 rst takes priority over all other inputs, including a simultaneous start.
REQ-037 rst mid-session aborts at that edge; no write is issued in the following cycle, and memory contents already written are left as-is.

Verification
REQ-038 Basic load: start; stream base=0x0, N=3, payload 30 F2 0A, csum 0xC8 -> writes (0,30),(1,F2),(2,0A) on consecutive cycles; done pulse; bytes_written=3; cpu_hold low the cycle after done.
REQ-039 Bad checksum: base=0x10, N=2, payload 01 02, csum 0x00 -> writes at 0x10 and 0x11 occur; err=1; no done; err clears on next start.
REQ-040 Bounds: MEM_SIZE=1024, base=0x3FF, N=2 -> ERR after second LEN byte; zero wEn pulses; in_ready=0 in the ERR cycle.
REQ-041 Zero length: base=0x20, N=0, csum 0x00 -> no writes; done pulse; bytes_written=0.
REQ-042 Throttling plus reset: in_valid toggled every other cycle during DATA -> writes spaced accordingly with correct addresses; then rst asserted after 2 of 4 payload bytes -> IDLE next cycle, wEn=0, cpu_hold=0, subsequent in_valid not consumed.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams a boot image (base, length, payload, checksum)
// into instruction memory while holding the CPU pipeline in stall.
module imem_loader #(
    parameter int MEM_SIZE = 1024,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             wEn,
    output logic [63:0]      waddr,
    output logic [7:0]       wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] bytes_written
);

    typedef enum logic [2:0] {
        IDLE, ADDR, LEN, DATA, CSUM, DONE, ERR
    } state_t;

    state_t          state;
    state_t          nextState;
    logic [2:0]      idx;
    logic [63:0]     base;
    logic [15:0]     lenReg;
    logic [15:0]     dataIdx;
    logic [7:0]      acc;
    logic            errFlag;
    logic [CNT_W-1:0] bytesWritten;
    logic            fire;
    logic [15:0]     fullLen;
    logic [64:0]     endAddr;

    assign err           = errFlag;
    assign bytes_written = bytesWritten;

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        fullLen   = {in_data, lenReg[7:0]};
        endAddr   = {1'b0, base} + 65'(fullLen);
        unique case (state)
            ADDR, LEN, DATA, CSUM: in_ready = 1'b1;
            default:               in_ready = 1'b0;
        endcase
        fire     = in_valid && in_ready;
        cpu_hold = (state != IDLE);
        done     = (state == DONE);
        unique case (state)
            IDLE: if (start) nextState = ADDR;
            ADDR: if (fire && idx == 3'd7) nextState = LEN;
            LEN: begin
                if (fire && idx == 3'd1) begin
                    if (endAddr > 65'(MEM_SIZE)) nextState = ERR;
                    else if (fullLen == 16'd0)   nextState = CSUM;
                    else                         nextState = DATA;
                end
            end
            DATA: if (fire && dataIdx == lenReg - 16'd1) nextState = CSUM;
            CSUM: if (fire) nextState = (in_data == acc) ? DONE : ERR;
            DONE: nextState = IDLE;
            ERR:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: header capture, payload write port, checksum and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            base         <= '0;
            lenReg       <= '0;
            dataIdx      <= '0;
            acc          <= '0;
            errFlag      <= 1'b0;
            bytesWritten <= '0;
            wEn          <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
        end else begin
            wEn <= (state == DATA) && fire;
            if (state == IDLE && start) begin
                idx          <= '0;
                dataIdx      <= '0;
                acc          <= '0;
                errFlag      <= 1'b0;
                bytesWritten <= '0;
            end
            if (state == ADDR && fire) begin
                base[{idx, 3'b000} +: 8] <= in_data;
                idx <= idx + 3'd1;
            end
            if (state == LEN && fire) begin
                if (idx == 3'd0) lenReg[7:0]  <= in_data;
                else             lenReg[15:8] <= in_data;
                idx <= idx + 3'd1;
            end
            if (state == DATA && fire) begin
                waddr        <= base + 64'(dataIdx);
                wdata        <= in_data;
                acc          <= acc ^ in_data;
                dataIdx      <= dataIdx + 16'd1;
                bytesWritten <= bytesWritten + CNT_W'(1);
            end
            if (nextState == ERR && state != ERR) errFlag <= 1'b1;
        end
    end

endmodule
